// File: rtl/regbus_host_bridge.sv
// Byte-stream command decoder that initiates register-bus reads and writes
// on behalf of a host, returning read data as two response bytes.
module regbus_host_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [6:0]  register_index,
  output logic        register_read,
  output logic        register_write,
  output logic [15:0] register_write_value,
  input  logic [15:0] register_read_value,
  output logic        cmd_timeout
);

  typedef enum logic [2:0] {
    IDLE, WR_HI, WR_LO, WR_ISSUE, RD_ISSUE, RD_WAIT, TX_HI, TX_LO
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] to_cnt;
  logic [15:0] hold;
  logic        in_wr;
  logic        rx_acc;
  logic        to_hit;

  assign in_wr  = (state == WR_HI) || (state == WR_LO);
  assign rx_acc = rx_valid && rx_ready;
  // An accepted byte in the limit cycle takes priority over the timeout.
  assign to_hit = in_wr && !rx_acc && (to_cnt == TO_LAST) && !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (rx_acc) state_nxt = rx_data[7] ? WR_HI : RD_ISSUE;
      WR_HI:    if (rx_acc) state_nxt = WR_LO;
                else if (to_hit) state_nxt = IDLE;
      WR_LO:    if (rx_acc) state_nxt = WR_ISSUE;
                else if (to_hit) state_nxt = IDLE;
      WR_ISSUE: state_nxt = IDLE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = TX_HI;
      TX_HI:    if (tx_ready) state_nxt = TX_LO;
      TX_LO:    if (tx_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    rx_ready       = 1'b0;
    register_read  = 1'b0;
    register_write = 1'b0;
    tx_valid       = 1'b0;
    tx_data        = 8'h00;
    cmd_timeout    = to_hit;
    if (!reset) begin
      unique case (state)
        IDLE, WR_HI, WR_LO: rx_ready = 1'b1;
        WR_ISSUE:           register_write = 1'b1;
        RD_ISSUE:           register_read = 1'b1;
        TX_HI: begin
          tx_valid = 1'b1;
          tx_data  = hold[15:8];
        end
        TX_LO: begin
          tx_valid = 1'b1;
          tx_data  = hold[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      register_index       <= '0;
      register_write_value <= '0;
      to_cnt               <= '0;
    end else begin
      if (rx_acc) begin
        unique case (state)
          IDLE:    register_index <= rx_data[6:0];
          WR_HI:   register_write_value[15:8] <= rx_data;
          WR_LO:   register_write_value[7:0]  <= rx_data;
          default: ;
        endcase
      end
      if (rx_acc || !in_wr) to_cnt <= '0;
      else                  to_cnt <= to_cnt + 16'd1;
    end
  end

  // Read data arrives one cycle after the strobe and is held for both tx bytes.
  always_ff @(posedge clk) begin
    if (state == RD_WAIT) hold <= register_read_value;
  end

endmodule

// File: tb/tb_regbus_host_bridge.sv
// Scoreboard bench for regbus_host_bridge: directed command bytes, expected
// bus strobes / tx bytes / timeouts queued and checked by a monitor.
module tb_regbus_host_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [6:0]  register_index;
  logic        register_read;
  logic        register_write;
  logic [15:0] register_write_value;
  logic [15:0] register_read_value = 16'h0000;
  logic        cmd_timeout;

  regbus_host_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .register_index(register_index), .register_read(register_read),
    .register_write(register_write), .register_write_value(register_write_value),
    .register_read_value(register_read_value), .cmd_timeout(cmd_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Responder: registered read data, preset contents until written.
  logic [15:0]  mem [128];
  logic [127:0] written = '0;

  function automatic logic [15:0] preset(input logic [6:0] idx);
    case (idx)
      7'd3:    return 16'h0C03;
      7'd6:    return 16'h000B;
      7'd16:   return 16'hBEEF;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (register_write) begin
      mem[register_index]     <= register_write_value;
      written[register_index] <= 1'b1;
    end
    if (register_read)
      register_read_value <= written[register_index] ? mem[register_index] : preset(register_index);
  end

  // Event encoding: {type, pad, index, value}; 1=write 2=read 3=tx byte 4=timeout
  function automatic logic [31:0] ev(input int t, input int idx, input int val);
    logic [3:0]  tt = t[3:0];
    logic [6:0]  ii = idx[6:0];
    logic [15:0] vv = val[15:0];
    return {tt, 5'd0, ii, vv};
  endfunction

  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic got(input logic [31:0] a);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got %h expected none", a);
    end else begin
      e = exp_q.pop_front();
      if (e !== a) begin
        errors++;
        $display("FAIL event got %h expected %h", a, e);
      end
    end
  endtask

  int   last_wr_cyc = -1, last_rd_cyc = -1, last_to_cyc = -1;
  logic prev_rd = 1'b0, prev_wr = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_rd <= 1'b0;
      prev_wr <= 1'b0;
    end else begin
      if (register_write) begin
        got(ev(1, register_index, register_write_value));
        last_wr_cyc <= cyc;
      end
      if (register_read) begin
        got(ev(2, register_index, 0));
        last_rd_cyc <= cyc;
      end
      if (tx_valid && tx_ready) got(ev(3, 0, tx_data));
      if (cmd_timeout) begin
        got(ev(4, 0, 0));
        last_to_cyc <= cyc;
      end
      if (register_read || register_write) begin
        checks++;
        if ((register_read && register_write) || (register_read && prev_rd) ||
            (register_write && prev_wr)) begin
          errors++;
          $display("FAIL strobe_rule rd=%0b wr=%0b prev_rd=%0b prev_wr=%0b",
                   register_read, register_write, prev_rd, prev_wr);
        end
      end
      prev_rd <= register_read;
      prev_wr <= register_write;
    end
  end

  task automatic send(input logic [7:0] b, output int acc);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte %h never accepted", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rx_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    c = cyc;
    if (!tx_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_tx tx_valid never rose");
    end
  endtask

  initial begin
    int a, d, k, c;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rx_ready_low", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rx_ready", rx_ready, 1);
    chk("post_rst_index", register_index, 0);
    chk("post_rst_wval", register_write_value, 0);
    chk("post_rst_strobes", {register_read, register_write, cmd_timeout}, 0);
    chk("post_rst_tx", {tx_valid, tx_data}, 0);
    @(posedge clk);
    #1;

    // Write 0x005A to index 1
    exp_q.push_back(ev(1, 1, 16'h005A));
    send(8'h81, a); send(8'h00, d); send(8'h5A, d); idle();
    wait_cycles(6);
    chk("wr_latency", last_wr_cyc - a, 3);

    // Read index 6 -> 0x000B
    exp_q.push_back(ev(2, 6, 0));
    exp_q.push_back(ev(3, 0, 8'h00));
    exp_q.push_back(ev(3, 0, 8'h0B));
    send(8'h06, a); idle();
    wait_tx(c);
    chk("rd_tx_latency", c - a, 3);
    chk("rd_strobe_latency", last_rd_cyc - a, 1);
    wait_cycles(4);
    chk("rd_done_rx_ready", rx_ready, 1);

    // Read 0xBEEF from index 16 with tx backpressure
    tx_ready = 1'b0;
    exp_q.push_back(ev(2, 16, 0));
    exp_q.push_back(ev(3, 0, 8'hBE));
    exp_q.push_back(ev(3, 0, 8'hEF));
    send(8'h10, a); idle();
    wait_tx(c);
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", {tx_valid, tx_data, rx_ready}, {1'b1, 8'hBE, 1'b0});
      @(negedge clk);
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_lo_rx_ready", {tx_valid, tx_data, rx_ready}, {1'b1, 8'hEF, 1'b0});
    wait_cycles(3);

    // Partial write abandoned by timeout, then a normal read
    exp_q.push_back(ev(4, 0, 0));
    send(8'h82, d); send(8'h12, k); idle();
    wait_cycles(12);
    chk("timeout_latency", last_to_cyc - k, 8);
    chk("timeout_rx_ready", rx_ready, 1);
    exp_q.push_back(ev(2, 3, 0));
    exp_q.push_back(ev(3, 0, 8'h0C));
    exp_q.push_back(ev(3, 0, 8'h03));
    send(8'h03, d); idle();
    wait_cycles(8);

    // Reset during WR_LO
    send(8'h81, d); send(8'h77, d); idle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wrlo_rx_ready", rx_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_wrlo_outputs",
        {register_index, register_write_value, register_read, register_write, tx_valid, rx_ready},
        {7'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;

    // Reset during TX_LO after the high byte has gone out
    tx_ready = 1'b0;
    exp_q.push_back(ev(2, 6, 0));
    exp_q.push_back(ev(3, 0, 8'h00));
    send(8'h06, d); idle();
    wait_tx(c);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
    @(negedge clk);
    chk("txlo_before_rst", {tx_valid, tx_data}, {1'b1, 8'h0B});
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    tx_ready = 1'b1;
    @(negedge clk);
    chk("rst_txlo_outputs", {tx_valid, tx_data, register_read, register_write, rx_ready},
        {1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    exp_q.push_back(ev(1, 1, 16'h005A));
    send(8'h81, d); send(8'h00, d); send(8'h5A, d); idle();
    wait_cycles(6);

    // Back-to-back stream: write, read-back, write
    exp_q.push_back(ev(1, 5, 16'h1234));
    exp_q.push_back(ev(2, 5, 0));
    exp_q.push_back(ev(3, 0, 8'h12));
    exp_q.push_back(ev(3, 0, 8'h34));
    exp_q.push_back(ev(1, 5, 16'hABCD));
    send(8'h85, d); send(8'h12, d); send(8'h34, d);
    send(8'h05, d);
    send(8'h85, d); send(8'hAB, d); send(8'hCD, d); idle();
    wait_cycles(20);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbus_host_bridge.md
# regbus_host_bridge

Byte-stream-to-register-bus initiator. Decodes a compact command protocol from a byte source (e.g. a UART receiver) and drives the same register bus the CPU core uses: `register_index`, `register_read`, `register_write`, `register_write_value` and `register_read_value`. Read results are returned as bytes to a byte sink. It sits beside the core and lets a host poke and peek the LED, seven-segment and button registers without running firmware.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, 65535: idle cycles allowed between bytes of a partial write command before it is discarded. Range 1..65535; 16-bit counter.

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `rx_data`  in  8  incoming command byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  bridge accepts a byte; transfer occurs on a cycle where `rx_valid && rx_ready`
- `tx_data`  out  8  outgoing response byte
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  sink accepts; transfer occurs on a cycle where `tx_valid && tx_ready`
- `register_index`  out  7  register address
- `register_read`  out  1  one-cycle read strobe
- `register_write`  out  1  one-cycle write strobe
- `register_write_value`  out  16  write data
- `register_read_value`  in  16  responder read data, valid the cycle after `register_read`
- `cmd_timeout`  out  1  one-cycle pulse when a partial command is discarded

## Operation

- Command byte: bit 7 selects write (1) or read (0). Bits 6:0 give the index.
- Write: a command byte, then a value-high byte, then a value-low byte. One `register_write` pulse follows. There is no response byte.
- Read: a command byte alone. One `register_read` pulse follows, then two response bytes, value[15:8] first and then value[7:0].
- States and transitions:
  - IDLE: `rx_ready`=1. An accepted byte latches bits 6:0 into `register_index`. Bit 7 = 1 goes to WR_HI; bit 7 = 0 goes to RD_ISSUE.
  - WR_HI: `rx_ready`=1. An accepted byte goes to `register_write_value[15:8]`, then the state moves to WR_LO.
  - WR_LO: `rx_ready`=1. An accepted byte goes to `register_write_value[7:0]`, then the state moves to WR_ISSUE.
  - WR_ISSUE: `register_write`=1, then IDLE.
  - RD_ISSUE: `register_read`=1, then RD_WAIT.
  - RD_WAIT: `register_read_value` is captured into a 16-bit holding register, then TX_HI.
  - TX_HI: `tx_valid`=1, `tx_data`=hold[15:8]. On `tx_ready`, go to TX_LO.
  - TX_LO: `tx_valid`=1, `tx_data`=hold[7:0]. On `tx_ready`, go to IDLE.
- `rx_ready`=0 in WR_ISSUE, RD_ISSUE, RD_WAIT, TX_HI and TX_LO. Bytes offered in these states are not consumed; the source holds them.
- `register_index` and `register_write_value` are registered. They hold their last values between transactions and change only on accepted bytes.
- `register_read` and `register_write` are never asserted together, and each is never high for two consecutive cycles.
- Timeout counter:
  - Clears on every accepted byte and on entry to WR_HI.
  - Increments each WR_HI/WR_LO cycle without an accepted byte.
  - On reaching `TIMEOUT_CYCLES`, the state moves to IDLE, `cmd_timeout` pulses for one cycle, and no write is issued.
  - An accepted byte in the same cycle as the count reaching its limit wins: the byte is consumed and there is no timeout.
- TX states have no timeout. Backpressure on `tx_ready` stalls the bridge indefinitely.

## Timing

- Reset values: state IDLE; `rx_ready`=0 during reset and 1 from the first cycle after it; `tx_valid`, `tx_data`, `register_index`, `register_read`, `register_write`, `register_write_value` and `cmd_timeout` all 0; counter 0.
- Reset mid-command or mid-response: the operation is abandoned. No strobe or `tx_valid` is asserted in the cycle after reset deasserts.
- Read: command byte accepted in cycle N.
  - `register_read`=1 in cycle N+1, with `register_index` already valid.
  - `register_read_value` is sampled at the end of N+2.
  - `tx_valid`=1 from N+3.
  - With `tx_ready` held high: high byte in N+3, low byte in N+4, `rx_ready`=1 in N+5.
- Write: low byte accepted in cycle K.
  - `register_write`=1 in cycle K+1, with index and value stable.
  - `rx_ready`=1 in K+2.
  - Back-to-back minimum is 4 cycles per write command.
- `tx_data` is stable while `tx_valid && !tx_ready`.

## Test plan

- After reset, bytes 0x81, 0x00, 0x5A with `rx_valid` held → one `register_write` pulse with index 1 and value 0x005A, 3 cycles after the first byte is accepted. No tx bytes.
- Byte 0x06 with a responder returning 0x000B registered on `register_read` → `register_read` pulses once with index 6; tx emits 0x00 then 0x0B. `register_write` stays 0.
- Read of 0xBEEF with `tx_ready` low for 10 cycles → `tx_valid` is held with `tx_data`=0xBE throughout; then 0xBE, 0xEF delivered; `rx_ready` stays 0 until done.
- `TIMEOUT_CYCLES`=8; send 0x82, 0x12, then stall → `cmd_timeout` pulses once, 8 cycles after 0x12; no `register_write`. A subsequent 0x03 performs a normal read of index 3.
- Assert `reset` for 1 cycle during WR_LO and during TX_LO → no strobes and no `tx_valid`; all outputs at reset values; the next command executes normally.
- Stream 0x85,0x12,0x34, 0x05, 0x85,0xAB,0xCD back-to-back → write 0x1234, read returns 0x12,0x34, write 0xABCD, in order, with strobes never overlapping.
